// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared state encoding and default sizing for the SPI master sequencer
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        XFER,
        HOLD,
        DONE
    } spi_ctrl_state_t;

    localparam int SPI_DATA_W  = 8;
    localparam int SPI_CLK_DIV = 4;

endpackage

// File: rtl/module_spi_edge_gen.sv
// rtl/module_spi_edge_gen.sv - SCLK divider; rise_o/fall_o flag the edge at which sclk_o toggles
module module_spi_edge_gen
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_div_cnt;
    logic          r_sclk;
    logic          w_wrap;

    assign w_wrap = en_i && (r_div_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (!en_i) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Ticks are high in the cycle before the toggle so the parent can register
    // its strobes in step with the new sclk_o level.
    assign rise_o = w_wrap && !r_sclk;
    assign fall_o = w_wrap && r_sclk;
    assign sclk_o = r_sclk;

endmodule

// File: rtl/module_spi_master_ctrl.sv
// rtl/module_spi_master_ctrl.sv - SPI mode-0 master sequencer; SPI_CTRL_BURST_EN chains frames from DONE
module module_spi_master_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    output logic sclk_o,
    output logic cs_n_o,
    output logic load_en_o,
    output logic shift_en_o,
    output logic sample_en_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    spi_ctrl_state_t r_state;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_bit_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_cs_n;
    logic            r_load_en;
    logic            r_shift_en;
    logic            r_sample_en;
    logic            w_rise;
    logic            w_fall;
    logic            w_last_bit;

    module_spi_edge_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_edge_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (r_state == XFER),
        .sclk_o (sclk_o),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    assign w_last_bit = (r_bit_cnt == BW'(DATA_W));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_load_en   <= 1'b0;
            r_shift_en  <= 1'b0;
            r_sample_en <= 1'b0;
        end else begin
            r_load_en   <= 1'b0;
            r_done      <= 1'b0;
            r_sample_en <= w_rise;
            // The final falling edge only closes the frame; the last bit stays put.
            r_shift_en  <= w_fall && !w_last_bit;
            if (w_rise) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state   <= LOAD;
                        r_load_en <= 1'b1;
                        r_cs_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                end
                LOAD: begin
                    r_state <= SETUP;
                    r_cnt   <= '0;
                end
                SETUP: begin
                    if (r_cnt == CW'(CLK_DIV - 1)) begin
                        r_state <= XFER;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (w_fall && w_last_bit) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (r_cnt == CW'(CLK_DIV - 1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
`ifdef SPI_CTRL_BURST_EN
                        r_cs_n  <= 1'b0;
`else
                        r_cs_n  <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
`ifdef SPI_CTRL_BURST_EN
                    if (start_i) begin
                        r_state   <= LOAD;
                        r_load_en <= 1'b1;
                        r_bit_cnt <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cs_n  <= 1'b1;
                    end
`else
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cs_n  <= 1'b1;
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cs_n  <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign cs_n_o      = r_cs_n;
    assign load_en_o   = r_load_en;
    assign shift_en_o  = r_shift_en;
    assign sample_en_o = r_sample_en;

endmodule

// File: tb/tb_module_spi_master_ctrl.sv
// tb/tb_module_spi_master_ctrl.sv - randomized bench for module_spi_master_ctrl with a TX shift register model
module tb_module_spi_master_ctrl;

    localparam int DW    = 8;
    localparam int CD    = 4;
    localparam int FRAME = 2 + 2 * CD + 2 * DW * CD;
`ifdef SPI_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic start, start_1;
    logic busy, done, sclk, cs_n, load_en, shift_en, sample_en;
    logic busy_1, done_1, sclk_1, cs_n_1, load_en_1, shift_en_1, sample_en_1;

    int vectors = 0;
    int errors  = 0;

    int f_len, f_rises, f_shifts, f_loads, f_edge_err, f_cs_err;
    logic [DW-1:0] f_rx;

    always #5 clk = ~clk;

    module_spi_master_ctrl #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .sclk_o(sclk), .cs_n_o(cs_n), .load_en_o(load_en), .shift_en_o(shift_en),
        .sample_en_o(sample_en)
    );

    module_spi_master_ctrl #(.DATA_W(DW), .CLK_DIV(1)) dut_1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_1), .busy_o(busy_1), .done_o(done_1),
        .sclk_o(sclk_1), .cs_n_o(cs_n_1), .load_en_o(load_en_1), .shift_en_o(shift_en_1),
        .sample_en_o(sample_en_1)
    );

    // One frame on dut, tracking MOSI through a model of the TX shift register.
    task automatic run_frame(input logic [DW-1:0] data);
        logic [DW-1:0] sr;
        logic prev, rise, fall;
        int fc;
        bit fin;
        sr = '0; prev = 1'b0; fc = 0; fin = 0;
        f_len = 0; f_rises = 0; f_shifts = 0; f_loads = 0; f_edge_err = 0; f_cs_err = 0; f_rx = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 300 && !fin; c++) begin
            if (c > 1) @(negedge clk);
            rise = sclk && !prev;
            fall = !sclk && prev;
            if (rise) f_rises++;
            if (fall) fc++;
            if (sample_en !== rise) f_edge_err++;
            if (shift_en !== (fall && fc < DW)) f_edge_err++;
            if (sample_en) f_rx = {f_rx[DW-2:0], sr[DW-1]};
            if (shift_en) f_shifts++;
            if (load_en) f_loads++;
            if (done) begin
                f_len = c;
                fin = 1;
                if (cs_n !== !BURST) f_cs_err++;
            end else if (cs_n !== 1'b0) begin
                f_cs_err++;
            end
            if (load_en) sr = data;
            else if (shift_en) sr = sr << 1;
            prev = sclk;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; start_1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if ({cs_n, sclk, busy, done, load_en, shift_en, sample_en} !== 7'b1000000) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b want 1000000", i,
                         {cs_n, sclk, busy, done, load_en, shift_en, sample_en});
            end
            vectors++;
            if ({cs_n_1, sclk_1, busy_1, done_1, load_en_1, shift_en_1, sample_en_1} !== 7'b1000000) begin
                errors++;
                $display("FAIL reset_outputs_div1 cycle %0d: got %b want 1000000", i,
                         {cs_n_1, sclk_1, busy_1, done_1, load_en_1, shift_en_1, sample_en_1});
            end
        end
        start = 1'b0; start_1 = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frames();
        logic [DW-1:0] data;
        for (int k = 0; k < 5; k++) begin
            data = (k == 0) ? 8'hA5 : DW'($urandom);
            run_frame(data);
            vectors++;
            if (f_len !== FRAME) begin
                errors++; $display("FAIL frame_len[%0d]: got %0d want %0d", k, f_len, FRAME);
            end
            vectors++;
            if (f_rises !== DW) begin
                errors++; $display("FAIL rise_count[%0d]: got %0d want %0d", k, f_rises, DW);
            end
            vectors++;
            if (f_shifts !== DW - 1) begin
                errors++; $display("FAIL shift_count[%0d]: got %0d want %0d", k, f_shifts, DW - 1);
            end
            vectors++;
            if (f_loads !== 1) begin
                errors++; $display("FAIL load_count[%0d]: got %0d want 1", k, f_loads);
            end
            vectors++;
            if (f_rx !== data) begin
                errors++; $display("FAIL mosi_bits[%0d]: got %h want %h", k, f_rx, data);
            end
            vectors++;
            if (f_edge_err !== 0) begin
                errors++; $display("FAIL strobe_alignment[%0d]: got %0d bad cycles want 0", k, f_edge_err);
            end
            vectors++;
            if (f_cs_err !== 0) begin
                errors++; $display("FAIL cs_n_window[%0d]: got %0d bad cycles want 0", k, f_cs_err);
            end
            repeat ($urandom_range(1, 5)) @(negedge clk);
            vectors++;
            if ({busy, cs_n, sclk} !== 3'b010) begin
                errors++; $display("FAIL idle_after[%0d]: got %b want 010", k, {busy, cs_n, sclk});
            end
        end
    endtask

    task automatic test_back_to_back();
        int c, loads, rises, dones, cs_high, done1, load2;
        c = 0; loads = 0; rises = 0; dones = 0; cs_high = 0; done1 = 0; load2 = 0;
        @(negedge clk); start = 1'b1;
        for (int i = 0; i < 400 && dones < 2; i++) begin
            @(negedge clk);
            c++;
            if (load_en) begin
                loads++;
                if (loads == 2) load2 = c;
            end
            if (sample_en) rises++;
            if (cs_n) cs_high++;
            if (done) begin
                dones++;
                if (dones == 1) done1 = c;
            end
        end
        start = 1'b0;
        vectors++;
        if (c !== (BURST ? 2 * FRAME : 2 * FRAME + 1)) begin
            errors++; $display("FAIL b2b_len: got %0d want %0d", c, BURST ? 2 * FRAME : 2 * FRAME + 1);
        end
        vectors++;
        if ({loads, rises, dones} !== {32'd2, 32'(2 * DW), 32'd2}) begin
            errors++; $display("FAIL b2b_counts: got loads %0d rises %0d dones %0d want 2 %0d 2",
                               loads, rises, dones, 2 * DW);
        end
        vectors++;
        if (cs_high !== (BURST ? 0 : 3)) begin
            errors++; $display("FAIL b2b_cs_high: got %0d want %0d", cs_high, BURST ? 0 : 3);
        end
        vectors++;
        if (load2 - done1 !== (BURST ? 1 : 2)) begin
            errors++; $display("FAIL b2b_gap: got %0d want %0d", load2 - done1, BURST ? 1 : 2);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, cs_n} !== 2'b01) begin
            errors++; $display("FAIL b2b_settle: got %b want 01", {busy, cs_n});
        end
    endtask

    task automatic test_abort();
        int seen, dones;
        bit busy_seen;
        seen = 0; dones = 0; busy_seen = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 200 && seen < 3; i++) begin
            @(negedge clk);
            if (sample_en) seen++;
        end
        vectors++;
        if (seen !== 3) begin
            errors++; $display("FAIL abort_reach: got %0d rises want 3", seen);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({cs_n, sclk, busy, shift_en, sample_en} !== 5'b10000) begin
            errors++; $display("FAIL abort_immediate: got %b want 10000", {cs_n, sclk, busy, shift_en, sample_en});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busy_seen = 1;
        end
        vectors++;
        if ({dones, busy_seen} !== {32'd0, 1'b0}) begin
            errors++; $display("FAIL abort_no_done: got dones %0d busy %0b want 0 0", dones, busy_seen);
        end
        begin
            logic [DW-1:0] data;
            data = DW'($urandom);
            run_frame(data);
            vectors++;
            if ({f_len, f_rises, f_rx} !== {32'(FRAME), 32'(DW), data}) begin
                errors++; $display("FAIL abort_recovery: got len %0d rises %0d rx %h want %0d %0d %h",
                                   f_len, f_rises, f_rx, FRAME, DW, data);
            end
        end
    endtask

    task automatic test_div1();
        int len, rises, toggles, overlap;
        logic prev;
        len = 0; rises = 0; toggles = 0; overlap = 0; prev = 1'b0;
        @(negedge clk); start_1 = 1'b1;
        @(negedge clk); start_1 = 1'b0;
        for (int c = 1; c <= 100 && len == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (sclk_1 !== prev) toggles++;
            if (sample_en_1) rises++;
            if (sample_en_1 && shift_en_1) overlap++;
            if (done_1) len = c;
            prev = sclk_1;
        end
        vectors++;
        if (len !== 2 + 2 + 2 * DW) begin
            errors++; $display("FAIL div1_len: got %0d want %0d", len, 2 + 2 + 2 * DW);
        end
        vectors++;
        if ({rises, toggles} !== {32'(DW), 32'(2 * DW)}) begin
            errors++; $display("FAIL div1_edges: got rises %0d toggles %0d want %0d %0d",
                               rises, toggles, DW, 2 * DW);
        end
        vectors++;
        if (overlap !== 0) begin
            errors++; $display("FAIL div1_overlap: got %0d want 0", overlap);
        end
    endtask

    initial begin
        start = 1'b0; start_1 = 1'b0; rst_n = 1'b0;
        test_reset();
        test_frames();
        test_div1();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
